// File: rtl/signed_mul_arbiter_if.sv
// rtl/signed_mul_arbiter_if.sv - requester, response and shared-multiplier signals of signed_mul_arbiter
interface signed_mul_arbiter_if #(
  parameter int W = 4
);
  logic           req0_valid;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req1_ready;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_prod;
  logic           rsp_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_rst;
  logic [2*W-1:0] mul_prod;
  logic           busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready, mul_prod,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, mul_a, mul_b, mul_rst, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready, mul_prod,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_prod, mul_a, mul_b, mul_rst, busy
  );
endinterface

// File: rtl/signed_mul_arbiter.sv
// rtl/signed_mul_arbiter.sv - round-robin sequencer sharing one unsigned multiplier for signed products
module signed_mul_arbiter #(
  parameter int W       = 4,
  parameter int MUL_LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  signed_mul_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MAG, MUL, FIX, RESP} state_t;

  localparam logic [3:0]     LAT   = 4'(MUL_LAT);
  localparam logic [W-1:0]   ONE_W = W'(1);
  localparam logic [2*W-1:0] ONE_P = (2*W)'(1);

  state_t         state, state_nxt;
  logic           last;
  logic           id_r;
  logic           sign;
  logic [W-1:0]   a_r, b_r;
  logic [W-1:0]   mag_a, mag_b;
  logic [3:0]     cnt;
  logic [2*W-1:0] p;
  logic [2*W-1:0] prod_r;
  logic           grant0, grant1, accept;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
  assign accept = (state == IDLE) & ~rst & (grant0 | grant1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAG;
      MAG:     state_nxt = MUL;
      MUL:     if (cnt == 4'd1) state_nxt = FIX;
      FIX:     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      id_r   <= 1'b0;
      sign   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      cnt    <= '0;
      p      <= '0;
      prod_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r  <= grant0 ? bus.req0_a : bus.req1_a;
          b_r  <= grant0 ? bus.req0_b : bus.req1_b;
          id_r <= grant1;
          last <= grant1;
        end
        MAG: begin
          // The most negative operand negates to itself, which is its correct unsigned magnitude.
          mag_a <= a_r[W-1] ? (~a_r + ONE_W) : a_r;
          mag_b <= b_r[W-1] ? (~b_r + ONE_W) : b_r;
          sign  <= a_r[W-1] ^ b_r[W-1];
          cnt   <= LAT;
        end
        MUL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) p <= bus.mul_prod;
        end
        FIX:     prod_r <= sign ? (~p + ONE_P) : p;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = (state == IDLE) & ~rst & grant0;
  assign bus.req1_ready = (state == IDLE) & ~rst & grant1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_r;
  assign bus.rsp_prod   = prod_r;
  assign bus.mul_a      = (state == MUL) ? mag_a : '0;
  assign bus.mul_b      = (state == MUL) ? mag_b : '0;
  assign bus.mul_rst    = rst | (state != MUL);
  assign bus.busy       = (state != IDLE);
endmodule
